// File: rtl/peak_readout_arb.sv
// peak_readout_arb: round-robin readout scheduler for N_CH peak-detector
// channels. Pops one peak at a time into a valid/ready stream tagged with the
// channel ID, and periodically pulses read_shift on idle channels so events
// parked in the detector's first stage reach its valid_out.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          low blocks new grants (a pending event still completes)
//   ch_valid        per-channel valid_out from the peak detectors
//   ch_peak         per-channel signed peak, channel i at [i*WD +: WD]
//   ch_read_shift   registered per-channel read_shift (grant pop or flush)
//   out_valid/ready output event handshake
//   out_data        {[timestamp,] ch_id, peak}, MSB first
//   event_count     events accepted downstream, wraps at 2**32
//
// Optional feature: define PEAK_ARB_TIMESTAMP_EN to prepend a TS_W-bit
// free-running timestamp, latched at the grant edge, to out_data.

module peak_readout_arb #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned WD           = 24,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned FLUSH_PERIOD = 64,
  parameter int unsigned TS_W         = 32,
`ifdef PEAK_ARB_TIMESTAMP_EN
  localparam int unsigned TS_USED     = 1,
`else
  localparam int unsigned TS_USED     = 0,
`endif
  localparam int unsigned OUT_W       = TS_USED * TS_W + CH_W + WD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_valid,
  input  logic [N_CH*WD-1:0]   ch_peak,
  output logic [N_CH-1:0]      ch_read_shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [31:0]          event_count
);

  localparam int unsigned CNT_W = (FLUSH_PERIOD > 1) ? $clog2(FLUSH_PERIOD) : 1;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   hold_id;
  logic [CNT_W-1:0]  flush_cnt;

`ifdef PEAK_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]   ts;
`endif

  logic              grant_hit;
  logic [CH_W-1:0]   grant_id;
  logic              grant_fire;
  logic [N_CH-1:0]   grant_mask;
  logic              flush_wrap;
  logic [N_CH-1:0]   flush_mask;
  logic [WD-1:0]     grant_peak;

  // First valid channel at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % N_CH;
      if (!grant_hit && ch_valid[idx]) begin
        grant_hit = 1'b1;
        grant_id  = CH_W'(idx);
      end
    end
  end

  assign grant_fire = (state == IDLE) && enable && grant_hit;
  assign grant_mask = grant_fire ? (N_CH'(1) << grant_id) : '0;
  assign grant_peak = ch_peak[grant_id*WD +: WD];

  // Flush only channels with nothing valid; the channel granted on the same
  // edge is masked so it never sees a second pulse.
  assign flush_wrap = (flush_cnt == CNT_W'(FLUSH_PERIOD - 1));
  assign flush_mask = flush_wrap ? (~ch_valid & ~grant_mask) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      hold_id       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      ch_read_shift <= '0;
      flush_cnt     <= '0;
      event_count   <= '0;
`ifdef PEAK_ARB_TIMESTAMP_EN
      ts            <= '0;
`endif
    end else begin
      flush_cnt     <= flush_wrap ? '0 : flush_cnt + 1'b1;
      ch_read_shift <= grant_mask | flush_mask;
`ifdef PEAK_ARB_TIMESTAMP_EN
      ts            <= ts + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (grant_fire) begin
`ifdef PEAK_ARB_TIMESTAMP_EN
            out_data <= {ts, grant_id, grant_peak};
`else
            out_data <= {grant_id, grant_peak};
`endif
            out_valid <= 1'b1;
            hold_id   <= grant_id;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            rr_ptr      <= (hold_id == CH_W'(N_CH - 1)) ? '0 : hold_id + 1'b1;
            event_count <= event_count + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_readout_arb.sv
// Testbench for peak_readout_arb: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter rules.
module tb_peak_readout_arb;

  localparam int unsigned N_CH = 4;
  localparam int unsigned WD   = 24;
  localparam int unsigned CH_W = 2;
  localparam int unsigned FP   = 64;
  localparam int unsigned TS_W = 32;
`ifdef PEAK_ARB_TIMESTAMP_EN
  localparam int unsigned OUT_W = TS_W + CH_W + WD;
`else
  localparam int unsigned OUT_W = CH_W + WD;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic [N_CH-1:0]      ch_valid = '0;
  logic [N_CH*WD-1:0]   ch_peak = '0;
  logic [N_CH-1:0]      ch_read_shift;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [OUT_W-1:0]     out_data;
  logic [31:0]          event_count;

  peak_readout_arb #(
    .N_CH(N_CH), .WD(WD), .CH_W(CH_W), .FLUSH_PERIOD(FP), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_valid(ch_valid),
    .ch_peak(ch_peak), .ch_read_shift(ch_read_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .event_count(event_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "is an event outstanding", which channel, where the
  // round-robin search starts, and how many edges since reset.
  bit               m_busy;
  int unsigned      m_ptr, m_gid, m_edges;
  logic [31:0]      m_count;
  logic [OUT_W-1:0] m_data;
  logic [N_CH-1:0]  m_rs;

  function automatic int unsigned pick(input logic [N_CH-1:0] v, input int unsigned from);
    for (int unsigned k = 0; k < N_CH; k++)
      if (v[(from + k) % N_CH]) return (from + k) % N_CH;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_gid = 0; m_edges = 0;
    m_count = '0; m_data = '0; m_rs = '0;
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] gmask;
    logic [31:0]     ts_val;
    logic [WD-1:0]   pk;
    logic [CH_W-1:0] gid;
    ts_val = 32'(m_edges);   // timestamp register value before this edge
    m_edges++;
    gmask = '0;
    if (!m_busy) begin
      if (enable && (ch_valid != 0)) begin
        m_gid = pick(ch_valid, m_ptr);
        pk  = ch_peak[m_gid*WD +: WD];
        gid = CH_W'(m_gid);
`ifdef PEAK_ARB_TIMESTAMP_EN
        m_data = {ts_val, gid, pk};
`else
        m_data = {gid, pk};
`endif
        m_busy = 1;
        gmask  = N_CH'(1) << m_gid;
      end
    end else if (out_ready) begin
      m_busy  = 0;
      m_ptr   = (m_gid + 1) % N_CH;
      m_count = m_count + 1;
    end
    m_rs = gmask;
    if (m_edges % FP == 0) m_rs = m_rs | (~ch_valid & ~gmask);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_busy));
    chk("read_shift", 64'(ch_read_shift), 64'(m_rs));
    chk("event_count", 64'(event_count), 64'(m_count));
    if (m_busy) chk("out_data", 64'(out_data), 64'(m_data));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rs", 64'(ch_read_shift), 64'd0);
    chk("rst_count", 64'(event_count), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [CH_W-1:0] id_of(input logic [OUT_W-1:0] d);
    return d[WD +: CH_W];
  endfunction

  initial begin
    int n, n2;
    int exp_order[5];
    logic [OUT_W-1:0] held;
    logic [WD-1:0]    neg;

    model_reset();
    #12;
    chk("init_valid", 64'(out_valid), 64'd0);
    chk("init_rs", 64'(ch_read_shift), 64'd0);
    chk("init_count", 64'(event_count), 64'd0);
    chk("init_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single event on channel 2.
    enable = 1; out_ready = 1; ch_valid = 4'b0100;
    ch_peak[2*WD +: WD] = 24'd1234;
    step();
    chk("single_id", 64'(id_of(out_data)), 64'd2);
    chk("single_peak", 64'(out_data[WD-1:0]), 64'd1234);
    chk("single_rs", 64'(ch_read_shift & 4'b1011), 64'd0);
    ch_valid = '0;
    step();
    chk("single_count", 64'(event_count), 64'd1);
    chk("single_rs_drop", 64'(ch_read_shift[2]), 64'd0);

    // Round-robin from a fresh reset with all channels pending.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    ch_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      ch_peak = {$urandom, $urandom, $urandom};
      step();
      if (i % 2 == 0) chk("rr_order", 64'(id_of(out_data)), 64'(exp_order[i/2]));
    end

    // Backpressure with channel 1 stalled across a flush wrap.
    ch_valid = 4'b0000; step(); step();
    ch_valid = 4'b0010; out_ready = 0;
    step();
    held = out_data;
    n = 0; n2 = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("bp_hold", 64'(out_data), 64'(held));
      if (ch_read_shift == 4'b1101) n++;
      if (ch_read_shift[1]) n2++;
    end
    chk("bp_flush_1101", 64'(n), 64'd1);
    chk("bp_ch1_never", 64'(n2), 64'd0);
    ch_valid = '0; out_ready = 1;
    step();
    chk("bp_done", 64'(out_valid), 64'd0);

    // All idle: flush all four channels once per 64 cycles.
    n = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (ch_read_shift == 4'b1111) n++;
    end
    chk("flush_pulses", 64'(n), 64'd2);

    // Negative peak held off by enable.
    enable = 0; ch_valid = 4'b1000;
    neg = -24'sd500;
    ch_peak[3*WD +: WD] = neg;
    for (int i = 0; i < 5; i++) step();
    enable = 1;
    step();
    chk("neg_peak", 64'(out_data[WD-1:0]), 64'hFFFE0C);
    chk("neg_id", 64'(id_of(out_data)), 64'd3);
    ch_valid = '0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      ch_valid  = N_CH'($urandom);
      ch_peak   = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      step();
    end

    // Reset in the middle of HOLD.
    enable = 1; ch_valid = 4'b1111; out_ready = 0;
    step(); step();
    do_reset();
    out_ready = 1;
    step();
    chk("post_rst_id", 64'(id_of(out_data)), 64'd0);
    chk("post_rst_count", 64'(event_count), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peak_readout_arb.md
Name: peak_readout_arb

Overview:
- Round-robin readout scheduler for N_CH parallel trapezoid-filter/peak-detector channels.
- Owns each channel's read_shift input:
  - pops one peak at a time into a single valid/ready output stream, tagged with channel ID;
  - periodically flushes idle channels so events parked in the detector's first stage reach valid_out.
- Sits between the per-channel pd2 instances and the event packer/readout FIFO.

Parameters:
- N_CH, 4, number of peak-detector channels (2..16)
- WD, 24, peak sample width in bits (matches the `WD+1 datapath)
- CH_W, 2, channel-ID width, must satisfy 2**CH_W >= N_CH
- FLUSH_PERIOD, 64, cycles between flush pulses (>=4)
- TS_W, 32, timestamp width (used only with PEAK_ARB_TIMESTAMP_EN)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new grants are issued
- ch_valid  in  N_CH  per-channel valid_out from pd2
- ch_peak  in  N_CH*WD  per-channel peak_out, channel i at bits [i*WD +: WD], signed
- ch_read_shift  out  N_CH  per-channel read_shift to pd2, registered
- out_valid  out  1  output event valid
- out_ready  in  1  downstream accept
- out_data  out  CH_W+WD (+TS_W)  {[ts,] ch_id, peak}, MSB first
- event_count  out  32  total events accepted downstream, wraps at 2**32

Behaviour:
- Reset (async, immediate) forces the following:
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, ch_read_shift=0;
  - flush counter=0, event_count=0, timestamp=0.
- State machine, 2 states:
  - IDLE: if enable and any ch_valid set, grant g = first set bit searching from rr_ptr upward, wrapping modulo N_CH. On that edge:
    - out_data <= {g, ch_peak[g]};
    - out_valid <= 1;
    - ch_read_shift[g] <= 1 for exactly one cycle;
    - state <= HOLD.
  - IDLE: if enable is low or no ch_valid is set, remain in IDLE.
  - HOLD: ch_read_shift returns to 0. On out_valid && out_ready:
    - out_valid <= 0;
    - rr_ptr <= (g+1) mod N_CH;
    - event_count += 1;
    - state <= IDLE.
- Latency and throughput:
  - ch_valid high in IDLE at cycle 0 gives out_valid high from cycle 1.
  - Fastest re-grant, with out_ready held high, is cycle 2, so max rate is 1 event per 2 cycles.
  - The pd2 pop completes at the end of cycle 1, so ch_valid seen in cycle 2 is already updated.
- out_data is stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on reset.
- enable low during HOLD: the pending event still completes; only new grants are blocked.
- Flush:
  - The flush counter runs free 0..FLUSH_PERIOD-1.
  - On wrap, a one-cycle pulse is registered on ch_read_shift[i] for every channel with ch_valid[i]=0.
  - The channel being granted that edge is excluded from the flush pulse, so a channel never gets two pulses.
  - Channels with ch_valid=1 are never flushed; only grants pop them.
  - Flush runs regardless of enable and state.
- ch_read_shift is never asserted for a channel whose ch_valid=1 except in its grant cycle.
- Round-robin: rr_ptr advances only on a completed handshake. Each channel is served at most once per N_CH grants while others are pending.
- Peak values pass through unmodified: signed, no truncation, no saturation.
- Reset mid-HOLD: the event is discarded. The pd2 pop already occurred, so loss of that event is accepted.

Optional Feature:
- Macro: PEAK_ARB_TIMESTAMP_EN
- Defined:
  - a TS_W-bit free-running timestamp counter increments every cycle and wraps;
  - its value at the grant edge is latched into out_data MSBs, so out_data width = TS_W+CH_W+WD.
- Undefined:
  - no counter exists, out_data width = CH_W+WD, and TS_W is unused.

Test Plan:
- Single event: rst, then ch_valid=4'b0100 with ch_peak[2]=1234, out_ready=1 → out_valid cycle 1 with data {2,1234}, ch_read_shift=4'b0100 for exactly one cycle, event_count=1.
- Round-robin: all four ch_valid held high, out_ready=1 → grant order 0,1,2,3,0; one grant every 2 cycles.
- Backpressure: out_ready=0 for 10 cycles after grant → out_data held constant, no further ch_read_shift, no new grant; out_ready=1 completes one handshake.
- Flush: all ch_valid=0, FLUSH_PERIOD=64 → ch_read_shift=4'b1111 pulsed once every 64 cycles. With ch_valid[1]=1 held, granted and stalled by out_ready=0 → flush mask 4'b1101, channel 1 never pulsed by flush.
- Negative peak / enable: ch_peak[3]=-500 with enable=0 → no grant. Raise enable → out_data peak field = 24'hFFFE0C.
- Async reset mid-HOLD: assert rst between clock edges → out_valid and ch_read_shift drop immediately; after release, rr_ptr=0 and event_count=0.
- PEAK_ARB_TIMESTAMP_EN defined: grant at timestamp 100 → out_data[TS field]=100.
